prio_req_encoder: RTL and testbench



---
 rtl/prio_req_pkg.sv | 21 ++
 rtl/prio_req_encoder_if.sv | 27 ++
 rtl/prio_pick.sv | 36 +++
 rtl/prio_req_encoder.sv | 84 ++++++++
 tb/tb_prio_req_encoder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/prio_req_pkg.sv
// Shared types and helpers for the registered priority/round-robin request encoder.
package prio_req_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Index width for n lines; never narrower than one bit so N_REQ=1 still has a port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_req_encoder_if.sv
// Request/mask inputs and valid/ready index output of the request encoder.
interface prio_req_encoder_if #(
  parameter int N_REQ = 8
);
  import prio_req_pkg::*;

  localparam int IDX_W = clog2(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] mask_i;
  logic             mode_rr_i;
  logic             out_ready_i;
  logic             out_valid_o;
  logic [IDX_W-1:0] out_idx_o;
  logic             any_pending_o;

  modport master (
    output req_i, mask_i, mode_rr_i, out_ready_i,
    input  out_valid_o, out_idx_o, any_pending_o
  );

  modport slave (
    input  req_i, mask_i, mode_rr_i, out_ready_i,
    output out_valid_o, out_idx_o, any_pending_o
  );

endinterface

// File: rtl/prio_pick.sv
// Combinational picker: first set bit of vec_i searching downward from ptr_i-1 with wrap.
module prio_pick
  import prio_req_pkg::*;
#(
  parameter int N_REQ = 8,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vec_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int               p;
  logic [IDX_W-1:0] pos;

  // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    p       = 0;
    pos     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      p = int'(ptr_i) - k;
      if (p < 0) begin
        p = p + N_REQ;
      end
      pos = IDX_W'(p);
      if (vec_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/prio_req_encoder.sv
// Sticky pending register + masked fixed/round-robin arbiter with a valid/ready index output.
module prio_req_encoder
  import prio_req_pkg::*;
#(
  parameter int N_REQ = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  prio_req_encoder_if.slave bus
);

  localparam int IDX_W = clog2(N_REQ);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             handshake;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  assign handshake = (state_q == ST_HOLD) && bus.out_ready_i;
  assign eligible  = pend_q & bus.mask_i;
  assign pick_ptr  = bus.mode_rr_i ? rr_ptr_q : '0;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_clr
      assign clr[gi] = handshake && (idx_q == IDX_W'(gi));
    end
  endgenerate

  prio_pick #(.N_REQ(N_REQ)) u_pick (
    .vec_i   (eligible),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // A request arriving in the grant cycle re-sets the bit being cleared.
  always_comb begin
    pend_d   = (pend_q & ~clr) | bus.req_i;
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          rr_ptr_d = idx_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.out_valid_o   = (state_q == ST_HOLD);
  assign bus.out_idx_o     = idx_q;
  assign bus.any_pending_o = |eligible;

endmodule

// File: tb/tb_prio_req_encoder.sv
// Directed bench for prio_req_encoder with N_REQ=8.
module tb_prio_req_encoder;

  logic clk_i;
  logic rst_i;
  int   total;
  int   bad;

  prio_req_encoder_if #(.N_REQ(8)) bus ();

  prio_req_encoder #(.N_REQ(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  int t2_exp[3]   = '{5, 2, 0};
  int t4_exp[9]   = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int t5_exp[4]   = '{7, 6, 5, 4};

  initial begin
    total = 0;
    bad   = 0;
    rst_i = 1'b1;
    bus.req_i       = 8'h00;
    bus.mask_i      = 8'hFF;
    bus.mode_rr_i   = 1'b0;
    bus.out_ready_i = 1'b0;

    #2;
    chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_idx", 32'(bus.out_idx_o), 32'd0);
    chk("rst_anyp", 32'(bus.any_pending_o), 32'd0);
    step();
    step();
    rst_i = 1'b0;

    // 1: idle with no requests
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t1_valid", 32'(bus.out_valid_o), 32'd0);
      chk("t1_idx", 32'(bus.out_idx_o), 32'd0);
      chk("t1_anyp", 32'(bus.any_pending_o), 32'd0);
    end
    $display("t1 idle: done");

    // 2: fixed priority, pulse 0x25
    bus.out_ready_i = 1'b1;
    bus.req_i = 8'h25;
    step();
    bus.req_i = 8'h00;
    chk("t2_anyp_start", 32'(bus.any_pending_o), 32'd1);
    chk("t2_bubble0", 32'(bus.out_valid_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_valid", 32'(bus.out_valid_o), 32'd1);
      chk("t2_idx", 32'(bus.out_idx_o), 32'(t2_exp[k]));
      $display("t2 grant %0d: idx=%0d", k, bus.out_idx_o);
      step();
      chk("t2_bubble", 32'(bus.out_valid_o), 32'd0);
    end
    chk("t2_anyp_end", 32'(bus.any_pending_o), 32'd0);

    // 3: held request, stalled consumer
    bus.out_ready_i = 1'b0;
    bus.req_i = 8'h80;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", 32'(bus.out_valid_o), 32'd1);
      chk("t3_hold_idx", 32'(bus.out_idx_o), 32'd7);
      step();
    end
    bus.out_ready_i = 1'b1;
    step();
    chk("t3_hs_valid", 32'(bus.out_valid_o), 32'd0);
    chk("t3_reset_pend", 32'(bus.any_pending_o), 32'd1);
    step();
    chk("t3_regrant_valid", 32'(bus.out_valid_o), 32'd1);
    chk("t3_regrant_idx", 32'(bus.out_idx_o), 32'd7);
    bus.req_i = 8'h00;
    step();
    chk("t3_end_valid", 32'(bus.out_valid_o), 32'd0);
    chk("t3_end_anyp", 32'(bus.any_pending_o), 32'd0);
    $display("t3 hold/regrant: done");

    // 4: round-robin with all lines held
    do_reset();
    bus.mode_rr_i = 1'b1;
    bus.req_i = 8'hFF;
    bus.out_ready_i = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      step();
      chk("t4_valid", 32'(bus.out_valid_o), 32'd1);
      chk("t4_idx", 32'(bus.out_idx_o), 32'(t4_exp[k]));
      $display("t4 grant %0d: idx=%0d", k, bus.out_idx_o);
      step();
      chk("t4_bubble", 32'(bus.out_valid_o), 32'd0);
    end
    bus.req_i = 8'h00;

    // 5: masked lines stay pending
    do_reset();
    bus.mode_rr_i = 1'b0;
    bus.mask_i = 8'h0F;
    bus.req_i = 8'hF1;
    step();
    bus.req_i = 8'h00;
    step();
    chk("t5_m_valid", 32'(bus.out_valid_o), 32'd1);
    chk("t5_m_idx", 32'(bus.out_idx_o), 32'd0);
    step();
    chk("t5_m_bubble", 32'(bus.out_valid_o), 32'd0);
    chk("t5_m_anyp", 32'(bus.any_pending_o), 32'd0);
    step();
    chk("t5_m_nogrant", 32'(bus.out_valid_o), 32'd0);
    bus.mask_i = 8'hFF;
    #1;
    chk("t5_unmask_anyp", 32'(bus.any_pending_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_valid", 32'(bus.out_valid_o), 32'd1);
      chk("t5_idx", 32'(bus.out_idx_o), 32'(t5_exp[k]));
      $display("t5 grant %0d: idx=%0d", k, bus.out_idx_o);
      step();
      chk("t5_bubble", 32'(bus.out_valid_o), 32'd0);
    end
    chk("t5_end_anyp", 32'(bus.any_pending_o), 32'd0);

    // 6: asynchronous reset during HOLD
    do_reset();
    bus.out_ready_i = 1'b0;
    bus.req_i = 8'h18;
    step();
    bus.req_i = 8'h00;
    step();
    chk("t6_pre_valid", 32'(bus.out_valid_o), 32'd1);
    chk("t6_pre_idx", 32'(bus.out_idx_o), 32'd4);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid_o), 32'd0);
    chk("t6_async_idx", 32'(bus.out_idx_o), 32'd0);
    chk("t6_async_anyp", 32'(bus.any_pending_o), 32'd0);
    #1;
    rst_i = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6_post_valid", 32'(bus.out_valid_o), 32'd0);
      chk("t6_post_anyp", 32'(bus.any_pending_o), 32'd0);
    end
    $display("t6 async reset: done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
